// File: rtl/theta_col_writer.sv
// Collects one theta column as a valid/ready element stream and emits it as
// 64-lane scatter writes into the row-major theta RAM (address = {row, col}).
module theta_col_writer #(
    parameter int LANES    = 64,
    parameter int DW       = 19,
    parameter int AW       = 14,
    parameter int ROW_BITS = 8,
    parameter int COL_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [COL_BITS-1:0]   col,
    output logic                  busy,
    output logic                  done,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [DW-1:0]  s_data,
    output logic [LANES*AW-1:0]   A,
    output logic [LANES*DW-1:0]   D,
    output logic                  WE
);
    localparam int LC_W = $clog2(LANES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // row_base of the final block; the column always splits into whole blocks
    localparam logic [ROW_BITS-1:0] LAST_BASE = ROW_BITS'((1 << ROW_BITS) - LANES);
    localparam logic [LC_W-1:0]     LAST_LANE = LC_W'(LANES - 1);

    logic [1:0]             state;
    logic [COL_BITS-1:0]    col_q;
    logic [ROW_BITS-1:0]    row_base;
    logic [LC_W-1:0]        lane_cnt;
    logic [LANES*DW-1:0]    stage_q;
    logic [LANES*DW-1:0]    stage_next;
    logic                   accept;

    function automatic logic [AW-1:0] lane_addr(input logic [ROW_BITS-1:0] base,
                                                input logic [COL_BITS-1:0] c,
                                                input int lane);
        logic [ROW_BITS-1:0] row;
        row = base + ROW_BITS'(lane);
        return {row, c};
    endfunction

    assign s_ready = (state == S_FILL);
    assign accept  = s_valid & s_ready;

    always_comb begin
        stage_next = stage_q;
        if (accept) begin
            stage_next[DW*lane_cnt +: DW] = s_data;
        end
    end

    // Staging lanes carry no control meaning, so they stay out of reset
    always_ff @(posedge clk) begin
        stage_q <= stage_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            WE       <= 1'b0;
            A        <= '0;
            D        <= '0;
            lane_cnt <= '0;
            row_base <= '0;
            col_q    <= '0;
        end else begin
            WE   <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        col_q    <= col;
                        row_base <= '0;
                        lane_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        if (lane_cnt == LAST_LANE) begin
                            lane_cnt <= '0;
                            state    <= S_WRITE;
                            WE       <= 1'b1;
                            D        <= stage_next;
                            for (int i = 0; i < LANES; i++) begin
                                A[AW*i +: AW] <= lane_addr(row_base, col_q, i);
                            end
                        end else begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    row_base <= row_base + ROW_BITS'(LANES);
                    if (row_base == LAST_BASE) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_FILL;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_theta_col_writer.sv
// Scoreboard bench for theta_col_writer: the driver queues expected (addr, data)
// per accepted element; the monitor checks all 64 lanes on every WE pulse.
module tb_theta_col_writer;
    localparam int LANES = 64;
    localparam int DW    = 19;
    localparam int AW    = 14;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [5:0]           col;
    logic                 busy;
    logic                 done;
    logic                 s_valid;
    logic                 s_ready;
    logic [DW-1:0]        s_data;
    logic [LANES*AW-1:0]  A;
    logic [LANES*DW-1:0]  D;
    logic                 WE;

    theta_col_writer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .col     (col),
        .busy    (busy),
        .done    (done),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .A       (A),
        .D       (D),
        .WE      (WE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } elem_t;

    elem_t exp_q[$];
    int    we_log[$];
    int    done_log[$];
    int    cyc = 0;
    int    start_cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    we_cnt = 0;
    int    last_we = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] val(input int row, input int mode);
        if (mode == 0) return DW'(row);
        return DW'(row * 1237 - 150000);
    endfunction

    function automatic logic [AW-1:0] addr(input int row, input int c);
        return {8'(row), 6'(c)};
    endfunction

    // Monitor: every WE consumes exactly 64 scoreboard entries, lane 0 first
    always @(negedge clk) begin
        elem_t e;
        if (!rst && WE) begin
            we_cnt++;
            we_log.push_back(cyc - start_cyc);
            if (last_we >= 0) chk("we_gap_ge_64", longint'(cyc - last_we >= 64), 1);
            last_we = cyc;
            for (int i = 0; i < LANES; i++) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 0, 1);
                    break;
                end
                e = exp_q.pop_front();
                chk($sformatf("A_lane%0d", i), longint'(A[AW*i +: AW]), longint'(e.a));
                chk($sformatf("D_lane%0d", i), longint'(D[DW*i +: DW]), longint'(e.d));
            end
        end
        if (!rst && done) done_log.push_back(cyc - start_cyc);
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        last_we = -1;
    endtask

    task automatic do_start(input int c);
        start = 1'b1;
        col = 6'(c);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic stream(input int c, input int mode, input bit toggle, input int limit);
        int row = 0;
        int n = 0;
        bit ph = 1'b1;
        elem_t e;
        while (row < limit && n < 3000) begin
            s_valid = toggle ? ph : 1'b1;
            ph = !ph;
            s_data = s_valid ? val(row, mode) : DW'($urandom);
            @(negedge clk);
            if (s_valid && s_ready) begin
                e.a = addr(row, c);
                e.d = val(row, mode);
                exp_q.push_back(e);
                row++;
            end
            @(posedge clk); #1;
            n++;
        end
        s_valid = 1'b0;
        chk("stream_accepted", row, limit);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", longint'(done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b1; s_valid = 1'b1;
        col = 6'($urandom); s_data = DW'($urandom);
        repeat (3) begin
            @(posedge clk); #1;
            col = 6'($urandom); s_data = DW'($urandom);
        end
        @(negedge clk);
        chk("rst_WE", longint'(WE), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_s_ready", longint'(s_ready), 0);
        chk("rst_A_zero", longint'(|A), 0);
        chk("rst_D_zero", longint'(|D), 0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; s_valid = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Continuous stream, col 5, data = row index
        we_cnt = 0; we_log.delete(); done_log.delete();
        do_start(5);
        stream(5, 0, 1'b0, 256);
        wait_done();
        @(posedge clk); #1;
        repeat (20) @(posedge clk); #1;
        chk("t1_we_count", we_cnt, 4);
        chk("t1_we_log_size", we_log.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t1_we_time%0d", k), (k < we_log.size()) ? we_log[k] : -1, 65 * (k + 1));
        chk("t1_done_time", (done_log.size() > 0) ? done_log[0] : -1, 261);
        chk("t1_sb_empty", exp_q.size(), 0);
        chk("t1_hold_A_lane0", longint'(A[AW*0 +: AW]), 12293);
        chk("t1_hold_A_lane63", longint'(A[AW*63 +: AW]), 16325);
        chk("t1_hold_D_lane63", longint'(D[DW*63 +: DW]), 255);
        chk("t1_busy_idle", longint'(busy), 0);

        // Toggling valid with signed data and garbage on idle cycles
        we_cnt = 0;
        do_start(5);
        stream(5, 1, 1'b1, 256);
        wait_done();
        @(posedge clk); #1;
        chk("t2_we_count", we_cnt, 4);
        chk("t2_sb_empty", exp_q.size(), 0);

        // Stray start and col change mid-transfer must be ignored
        we_cnt = 0;
        do_start(5);
        fork
            stream(5, 0, 1'b0, 256);
            begin
                repeat (80) @(posedge clk);
                #2; start = 1'b1; col = 6'd9;
                @(posedge clk);
                #2; start = 1'b0;
            end
        join
        wait_done();
        @(posedge clk); #1;
        chk("t3_we_count", we_cnt, 4);
        chk("t3_sb_empty", exp_q.size(), 0);

        // Reset after 100 accepted elements discards the partial block
        we_cnt = 0;
        do_start(20);
        stream(20, 0, 1'b0, 100);
        do_reset();
        @(negedge clk);
        chk("t4_busy_after_rst", longint'(busy), 0);
        chk("t4_ready_after_rst", longint'(s_ready), 0);
        @(posedge clk); #1;
        repeat (70) @(posedge clk); #1;
        chk("t4_we_count_partial", we_cnt, 1);
        do_start(63);
        stream(63, 0, 1'b0, 256);
        wait_done();
        @(posedge clk); #1;
        chk("t4_we_count_total", we_cnt, 5);
        chk("t4_sb_empty", exp_q.size(), 0);

        // start during done is ignored; start in the following idle cycle is taken
        do_start(7);
        stream(7, 0, 1'b0, 256);
        wait_done();
        start = 1'b1; col = 6'd7;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_busy_start_in_done", longint'(busy), 0);
        chk("t5_ready_start_in_done", longint'(s_ready), 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t5_busy_start_in_idle", longint'(busy), 1);
        chk("t5_ready_start_in_idle", longint'(s_ready), 1);
        @(posedge clk); #1;
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
